// File: rtl/audio_tone_sched.sv
// Purpose: round-robin scheduler for two tone requesters sharing one PWM audio channel, with a silent gap after each tone.
// Latency: req seen at a clock edge -> ack in the following cycle -> first PWM sample one cycle after that.
// Backpressure: requesters hold req until their ack; requests are ignored during PLAY/GAP and while abort is high.
module audio_tone_sched #(
  parameter int PERIOD      = 512,
  parameter int DW          = 16,
  parameter int LW          = 16,
  parameter int GAP_PERIODS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [DW-1:0] duty0,
  input  logic [DW-1:0] duty1,
  input  logic [LW-1:0] len0,
  input  logic [LW-1:0] len1,
  input  logic          abort,
  output logic [1:0]    ack,
  output logic          done,
  output logic          grant_id,
  output logic          busy,
  output logic          AUD_SD,
  output logic          AUD_PWM
);

  // Counter width covers 0..PERIOD; compare width covers both counter and duty.
  localparam int CW       = (PERIOD < 1) ? 1 : $clog2(PERIOD + 1);
  localparam int MW       = (CW > DW) ? CW : DW;
  localparam int GAP_LAST = (GAP_PERIODS > 0) ? GAP_PERIODS - 1 : 0;

  localparam logic [CW-1:0] CNT_MAX     = CW'(PERIOD);
  localparam logic [LW-1:0] GAP_LAST_PC = LW'(GAP_LAST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] pc_q, pc_d;
  logic [DW-1:0] duty_q, duty_d;
  logic [LW-1:0] len_q, len_d;
  logic          last_q, last_d;
  logic          gid_q, gid_d;
  logic [1:0]    ack_q, ack_d;
  logic          done_q, done_d;
  logic          pwm_q, pwm_d;

  logic          win;
  logic [DW-1:0] duty_sel;
  logic [LW-1:0] len_sel;
  logic          period_end;
  logic          pwm_cmp;
  logic          tone_last;
  logic          gap_last;

  // Arbitration and period bookkeeping shared by the state logic.
  always_comb begin
    // On a tie the requester that did not win last time takes the channel.
    if (req == 2'b11) begin
      win = ~last_q;
    end else begin
      win = req[1];
    end
    duty_sel   = win ? duty1 : duty0;
    len_sel    = win ? len1 : len0;
    period_end = (cnt_q == CNT_MAX);
    pwm_cmp    = (MW'(cnt_q) < MW'(duty_q));
    tone_last  = (pc_q == (len_q - LW'(1)));
    gap_last   = (pc_q == GAP_LAST_PC);
  end

  // State register and all datapath registers; reset is asynchronous.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      duty_q  <= '0;
      len_q   <= '0;
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      ack_q   <= 2'b00;
      done_q  <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      duty_q  <= duty_d;
      len_q   <= len_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      pwm_q   <= pwm_d;
    end
  end

  // Next-state and next-output logic; pulses and PWM default low every cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    duty_d  = duty_q;
    len_d   = len_q;
    last_d  = last_q;
    gid_d   = gid_q;
    ack_d   = 2'b00;
    done_d  = 1'b0;
    pwm_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Still IDLE right after an ack means the granted tone had zero length:
        // it completes immediately.
        done_d = |ack_q;
        if (!abort && (|req)) begin
          ack_d  = win ? 2'b10 : 2'b01;
          duty_d = duty_sel;
          len_d  = len_sel;
          gid_d  = win;
          last_d = win;
          cnt_d  = '0;
          pc_d   = '0;
          if (len_sel != '0) begin
            state_d = S_PLAY;
          end
        end
      end

      S_PLAY: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          pc_d    = '0;
        end else begin
          pwm_d = pwm_cmp;
          if (period_end) begin
            cnt_d = '0;
            if (tone_last) begin
              // Last sample is dropped so the gap starts with the output low.
              pwm_d  = 1'b0;
              done_d = 1'b1;
              pc_d   = '0;
              if (GAP_PERIODS > 0) begin
                state_d = S_GAP;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              pc_d = pc_q + LW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          pc_d    = '0;
        end else if (period_end) begin
          cnt_d = '0;
          if (gap_last) begin
            pc_d    = '0;
            state_d = S_IDLE;
          end else begin
            pc_d = pc_q + LW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        pc_d    = '0;
      end
    endcase
  end

  // Outputs are taken straight from registers so they clear with reset.
  assign ack      = ack_q;
  assign done     = done_q;
  assign grant_id = gid_q;
  assign busy     = (state_q != S_IDLE);
  assign AUD_SD   = (state_q == S_PLAY);
  assign AUD_PWM  = pwm_q;

endmodule

// File: tb/tb_audio_tone_sched.sv
// Directed bench for audio_tone_sched with PERIOD=15 and GAP_PERIODS=2.
// Inputs change 1 time unit after a rising edge; outputs are observed at the same point.
module tb_audio_tone_sched;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [15:0] duty0;
  logic [15:0] duty1;
  logic [15:0] len0;
  logic [15:0] len1;
  logic        abort;
  logic [1:0]  ack;
  logic        done;
  logic        grant_id;
  logic        busy;
  logic        AUD_SD;
  logic        AUD_PWM;

  int checks = 0;
  int errors = 0;

  audio_tone_sched #(
    .PERIOD(15),
    .DW(16),
    .LW(16),
    .GAP_PERIODS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .duty0(duty0),
    .duty1(duty1),
    .len0(len0),
    .len1(len1),
    .abort(abort),
    .ack(ack),
    .done(done),
    .grant_id(grant_id),
    .busy(busy),
    .AUD_SD(AUD_SD),
    .AUD_PWM(AUD_PWM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for busy to drop; reports the cycles taken or -1.
  task automatic wait_idle(output int cyc);
    cyc = -1;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        cyc = i;
        break;
      end
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Plays one requester-0 tone and collects counts from the ack cycle until busy drops.
  task automatic run_tone(input logic [15:0] d, input logic [15:0] l,
                          output int sd, output int pwm_play, output int pwm_off,
                          output int dn, output int cyc);
    sd = 0; pwm_play = 0; pwm_off = 0; dn = 0; cyc = -1;
    duty0 = d;
    len0  = l;
    req   = 2'b01;
    step();
    req = 2'b00;
    for (int i = 0; i < 200; i++) begin
      if (AUD_SD) sd++;
      if (AUD_SD && AUD_PWM) pwm_play++;
      if (!AUD_SD && AUD_PWM) pwm_off++;
      if (done) dn++;
      if (!busy) begin
        cyc = i;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({ack, done, grant_id, busy, AUD_SD, AUD_PWM} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000000", {ack, done, grant_id, busy, AUD_SD, AUD_PWM});
    end
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({ack, busy} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got ack=%b busy=%b want 00/0", ack, busy);
    end
  endtask

  task automatic test_basic();
    int sd_cnt, pwm_hi, pat_err, done_cnt, done_at, gap_cnt, ack_cnt, end_at;
    logic exp_pwm;
    sd_cnt = 0; pwm_hi = 0; pat_err = 0; done_cnt = 0; done_at = -1;
    gap_cnt = 0; ack_cnt = 0; end_at = -1;
    duty0 = 16'd4;
    len0  = 16'd3;
    req   = 2'b01;
    step();
    checks++;
    if ({ack, grant_id, busy, AUD_SD} !== 5'b01011) begin
      errors++;
      $display("FAIL basic_ack: got ack=%b gid=%b busy=%b sd=%b want 01/0/1/1", ack, grant_id, busy, AUD_SD);
    end
    req = 2'b00;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        end_at = i;
        break;
      end
      exp_pwm = (i >= 1) && (i < 48) && (((i - 1) % 16) < 4);
      if (AUD_PWM !== exp_pwm) pat_err++;
      if (AUD_SD) sd_cnt++;
      if (AUD_PWM) pwm_hi++;
      if (busy && !AUD_SD) gap_cnt++;
      if (ack != 2'b00) ack_cnt++;
      if (done) begin
        done_cnt++;
        done_at = i;
      end
      step();
    end
    checks++;
    if (sd_cnt != 48) begin
      errors++;
      $display("FAIL basic_sd_cycles: got %0d want 48", sd_cnt);
    end
    checks++;
    if (pwm_hi != 12 || pat_err != 0) begin
      errors++;
      $display("FAIL basic_pwm: highs %0d want 12, pattern errors %0d want 0", pwm_hi, pat_err);
    end
    checks++;
    if (done_cnt != 1 || done_at != 48) begin
      errors++;
      $display("FAIL basic_done: count %0d at %0d want 1 at 48", done_cnt, done_at);
    end
    checks++;
    if (gap_cnt != 32 || end_at != 80) begin
      errors++;
      $display("FAIL basic_gap: gap %0d end %0d want 32/80", gap_cnt, end_at);
    end
    checks++;
    if (ack_cnt != 1) begin
      errors++;
      $display("FAIL basic_single_ack: got %0d want 1", ack_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] ack_v [4];
    logic       gid_v [4];
    int         at_v  [4];
    int         n, sd_cnt, cyc;
    logic [1:0] exp_ack;
    n = 0; sd_cnt = 0;
    do_reset();
    duty0 = 16'd4; duty1 = 16'd4;
    len0  = 16'd1; len1  = 16'd1;
    req   = 2'b11;
    for (int i = 0; i < 300 && n < 4; i++) begin
      step();
      if (ack != 2'b00) begin
        ack_v[n] = ack;
        gid_v[n] = grant_id;
        at_v[n]  = i;
        n++;
      end
      if (AUD_SD && n >= 1 && n < 4) sd_cnt++;
    end
    req = 2'b00;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL rr_ack_count: got %0d want 4", n);
    end else begin
      for (int k = 0; k < 4; k++) begin
        exp_ack = (k % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if (ack_v[k] !== exp_ack || gid_v[k] !== exp_ack[1]) begin
          errors++;
          $display("FAIL rr_order_%0d: ack=%b gid=%b want %b/%b", k, ack_v[k], gid_v[k], exp_ack, exp_ack[1]);
        end
      end
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (at_v[k] - at_v[k-1] != 49) begin
          errors++;
          $display("FAIL rr_spacing_%0d: got %0d want 49", k, at_v[k] - at_v[k-1]);
        end
      end
      checks++;
      if (sd_cnt != 48) begin
        errors++;
        $display("FAIL rr_sd_cycles: got %0d want 48", sd_cnt);
      end
    end
    wait_idle(cyc);
    checks++;
    if (cyc < 0) begin
      errors++;
      $display("FAIL rr_idle_timeout: busy=%b want 0", busy);
    end
  endtask

  task automatic test_duty_extremes();
    int sd, pp, po, dn, cyc;
    run_tone(16'd0, 16'd1, sd, pp, po, dn, cyc);
    checks++;
    if (sd != 16 || pp != 0 || po != 0 || dn != 1 || cyc != 48) begin
      errors++;
      $display("FAIL duty0_zero: sd=%0d pwm=%0d off=%0d done=%0d cyc=%0d want 16/0/0/1/48", sd, pp, po, dn, cyc);
    end
    run_tone(16'd20, 16'd1, sd, pp, po, dn, cyc);
    checks++;
    if (sd != 16 || pp != 15 || po != 0 || dn != 1 || cyc != 48) begin
      errors++;
      $display("FAIL duty0_full: sd=%0d pwm=%0d off=%0d done=%0d cyc=%0d want 16/15/0/1/48", sd, pp, po, dn, cyc);
    end
  endtask

  task automatic test_zero_len();
    duty0 = 16'd4;
    len0  = 16'd0;
    req   = 2'b01;
    step();
    req = 2'b00;
    checks++;
    if ({ack, done, AUD_SD, busy} !== 5'b01000) begin
      errors++;
      $display("FAIL zlen_ack: ack=%b done=%b sd=%b busy=%b want 01/0/0/0", ack, done, AUD_SD, busy);
    end
    step();
    checks++;
    if ({ack, done, AUD_SD, busy} !== 5'b00100) begin
      errors++;
      $display("FAIL zlen_done: ack=%b done=%b sd=%b busy=%b want 00/1/0/0", ack, done, AUD_SD, busy);
    end
    step();
    checks++;
    if ({ack, done, AUD_SD, busy} !== 5'b00000) begin
      errors++;
      $display("FAIL zlen_after: ack=%b done=%b sd=%b busy=%b want 00/0/0/0", ack, done, AUD_SD, busy);
    end
  endtask

  task automatic test_abort();
    int dn, cyc;
    dn = 0;
    duty0 = 16'd20;
    len0  = 16'd3;
    req   = 2'b01;
    step();
    req = 2'b00;
    checks++;
    if (ack !== 2'b01) begin
      errors++;
      $display("FAIL abort_first_ack: got %b want 01", ack);
    end
    repeat (10) step();
    checks++;
    if ({AUD_SD, AUD_PWM, busy} !== 3'b111) begin
      errors++;
      $display("FAIL abort_pre: sd=%b pwm=%b busy=%b want 1/1/1", AUD_SD, AUD_PWM, busy);
    end
    abort = 1'b1;
    duty1 = 16'd4;
    len1  = 16'd1;
    req   = 2'b10;
    step();
    abort = 1'b0;
    checks++;
    if ({busy, AUD_SD, AUD_PWM, done, ack} !== 6'b000000) begin
      errors++;
      $display("FAIL abort_stop: busy=%b sd=%b pwm=%b done=%b ack=%b want all 0", busy, AUD_SD, AUD_PWM, done, ack);
    end
    step();
    req = 2'b00;
    checks++;
    if ({ack, grant_id, AUD_SD} !== 4'b1011) begin
      errors++;
      $display("FAIL abort_next_grant: ack=%b gid=%b sd=%b want 10/1/1", ack, grant_id, AUD_SD);
    end
    cyc = -1;
    for (int i = 0; i < 200; i++) begin
      if (done) dn++;
      if (!busy) begin
        cyc = i;
        break;
      end
      step();
    end
    checks++;
    if (dn != 1 || cyc != 48) begin
      errors++;
      $display("FAIL abort_followup: done=%0d cyc=%0d want 1/48", dn, cyc);
    end
  endtask

  task automatic test_async_reset();
    int cyc;
    duty1 = 16'd20;
    len1  = 16'd3;
    req   = 2'b10;
    step();
    req = 2'b00;
    repeat (5) step();
    checks++;
    if ({AUD_SD, AUD_PWM, grant_id} !== 3'b111) begin
      errors++;
      $display("FAIL arst_pre: sd=%b pwm=%b gid=%b want 1/1/1", AUD_SD, AUD_PWM, grant_id);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({ack, done, grant_id, busy, AUD_SD, AUD_PWM} !== 7'b0) begin
      errors++;
      $display("FAIL arst_async: got %b want 0000000", {ack, done, grant_id, busy, AUD_SD, AUD_PWM});
    end
    #2;
    rst = 1'b0;
    req = 2'b10;
    step();
    req = 2'b00;
    checks++;
    if ({ack, grant_id, busy, AUD_SD} !== 5'b10111) begin
      errors++;
      $display("FAIL arst_regrant: ack=%b gid=%b busy=%b sd=%b want 10/1/1/1", ack, grant_id, busy, AUD_SD);
    end
    wait_idle(cyc);
    checks++;
    if (cyc != 80) begin
      errors++;
      $display("FAIL arst_tone_len: idle after %0d want 80", cyc);
    end
  endtask

  initial begin
    rst   = 1'b1;
    req   = 2'b00;
    duty0 = '0;
    duty1 = '0;
    len0  = '0;
    len1  = '0;
    abort = 1'b0;
    test_reset();
    test_basic();
    test_round_robin();
    test_duty_extremes();
    test_zero_len();
    test_abort();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
